// File: rtl/rvs_xrf_wb_arbiter_if.sv
// Bus bundle between the RVV retire stage, the writeback arbiter and the scalar XRF write ports.
interface rvs_xrf_wb_arbiter_if #(
   parameter int NUM_RT_UOP = 4,
   parameter int NUM_XRF_WP = 2,
   parameter int DEPTH      = 8,
   parameter int XLEN       = 32,
   parameter int AW         = 5
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_RT_UOP-1:0]      rt_xrf_valid_rvv2rvs;
   logic [NUM_RT_UOP*AW-1:0]   rt_xrf_addr_rvv2rvs;
   logic [NUM_RT_UOP*XLEN-1:0] rt_xrf_data_rvv2rvs;
   logic [NUM_RT_UOP-1:0]      rt_xrf_ready_rvs2rvv;
   logic                       xrf_wp_stall;
   logic [NUM_XRF_WP-1:0]      xrf_wp_en;
   logic [NUM_XRF_WP*AW-1:0]   xrf_wp_addr;
   logic [NUM_XRF_WP*XLEN-1:0] xrf_wp_data;
   logic [CW-1:0]              wb_count;
   logic                       wb_idle;

   modport slave (
      input  rt_xrf_valid_rvv2rvs, rt_xrf_addr_rvv2rvs, rt_xrf_data_rvv2rvs, xrf_wp_stall,
      output rt_xrf_ready_rvs2rvv, xrf_wp_en, xrf_wp_addr, xrf_wp_data, wb_count, wb_idle
   );

   modport master (
      output rt_xrf_valid_rvv2rvs, rt_xrf_addr_rvv2rvs, rt_xrf_data_rvv2rvs, xrf_wp_stall,
      input  rt_xrf_ready_rvs2rvv, xrf_wp_en, xrf_wp_addr, xrf_wp_data, wb_count, wb_idle
   );
endinterface

// File: rtl/rvs_xrf_wb_arbiter.sv
// RVV->XRF writeback buffer: in-order multi-lane accept into a circular FIFO, oldest-first drain
// onto the scalar write ports, never issuing two same-cycle writes to one register.
module rvs_xrf_wb_arbiter #(
   parameter int NUM_RT_UOP = 4,
   parameter int NUM_XRF_WP = 2,
   parameter int DEPTH      = 8,
   parameter int XLEN       = 32,
   parameter int AW         = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rvs_xrf_wb_arbiter_if.slave    bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]         addr_mem [DEPTH];
   logic [XLEN-1:0]       data_mem [DEPTH];
   logic [PW-1:0]         rd_ptr_q;
   logic [PW-1:0]         wr_ptr_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic [CW-1:0]         free_slots;
   logic [CW-1:0]         n_acc;
   logic [CW-1:0]         n_pop;
   logic [NUM_RT_UOP-1:0] ready;
   logic [NUM_RT_UOP-1:0] accept;
   logic [NUM_XRF_WP-1:0] issue;
   logic                  blocked;
   logic                  hazard;
   logic [AW-1:0]         head_addr [NUM_XRF_WP];
   logic [XLEN-1:0]       head_data [NUM_XRF_WP];

   // Ready looks only at registered occupancy; a same-cycle pop gives no extra credit.
   always_comb begin
      free_slots = CW'(DEPTH) - count_q;
      ready      = '0;
      accept     = '0;
      n_acc      = '0;
      for (int i = 0; i < NUM_RT_UOP; i++) begin
         ready[i]  = rst_n && (CW'(i) < free_slots);
         accept[i] = bus.rt_xrf_valid_rvv2rvs[i] && ready[i];
         n_acc     = n_acc + CW'(accept[i]);
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_XRF_WP; j++) begin
         head_addr[j] = addr_mem[rd_ptr_q + PW'(j)];
         head_data[j] = data_mem[rd_ptr_q + PW'(j)];
      end
   end

   // Issue the longest head prefix with pairwise-distinct addresses; the first repeat and
   // everything younger wait for a later cycle.
   always_comb begin
      issue   = '0;
      n_pop   = '0;
      blocked = bus.xrf_wp_stall;
      hazard  = 1'b0;
      for (int j = 0; j < NUM_XRF_WP; j++) begin
         hazard = 1'b0;
         for (int k = 0; k < NUM_XRF_WP; k++) begin
            if (k < j && head_addr[k] == head_addr[j]) begin
               hazard = 1'b1;
            end
         end
         if (!blocked && (CW'(j) < count_q) && !hazard) begin
            issue[j] = 1'b1;
            n_pop    = CW'(j + 1);
         end else begin
            blocked = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q + n_acc - n_pop;
      for (int j = 0; j < NUM_XRF_WP; j++) begin
         bus.xrf_wp_en[j]                 = issue[j] && rst_n;
         bus.xrf_wp_addr[j*AW +: AW]      = (issue[j] && rst_n) ? head_addr[j] : '0;
         bus.xrf_wp_data[j*XLEN +: XLEN]  = (issue[j] && rst_n) ? head_data[j] : '0;
      end
   end

   assign bus.rt_xrf_ready_rvs2rvv = ready;
   assign bus.wb_count             = count_q;
   assign bus.wb_idle              = (count_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_q + PW'(n_pop);
         wr_ptr_q <= wr_ptr_q + PW'(n_acc);
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RT_UOP; i++) begin
         if (accept[i]) begin
            addr_mem[wr_ptr_q + PW'(i)] <= bus.rt_xrf_addr_rvv2rvs[i*AW +: AW];
            data_mem[wr_ptr_q + PW'(i)] <= bus.rt_xrf_data_rvv2rvs[i*XLEN +: XLEN];
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_RT_UOP - 1; g++) begin : g_prefix_chk
         a_valid_prefix: assert property (@(posedge clk) disable iff (!rst_n)
            !bus.rt_xrf_valid_rvv2rvs[g] |-> !bus.rt_xrf_valid_rvv2rvs[g+1]);
      end
   endgenerate

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_rvs_xrf_wb_arbiter.sv
// Directed plus randomized bench for rvs_xrf_wb_arbiter against a queue-based reference model.
module tb_rvs_xrf_wb_arbiter;
   localparam int NRT   = 4;
   localparam int NWP   = 2;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;
   localparam int AW    = 5;

   typedef struct {
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
   } ent_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ent_t            q[$];
   logic [AW-1:0]   lane_addr [NRT];
   logic [XLEN-1:0] lane_data [NRT];
   logic [XLEN-1:0] dut_xrf   [32];

   rvs_xrf_wb_arbiter_if #(.NUM_RT_UOP(NRT), .NUM_XRF_WP(NWP), .DEPTH(DEPTH),
                           .XLEN(XLEN), .AW(AW)) bus ();

   rvs_xrf_wb_arbiter #(.NUM_RT_UOP(NRT), .NUM_XRF_WP(NWP), .DEPTH(DEPTH),
                        .XLEN(XLEN), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive after the falling edge, compare against the model, update the model.
   task automatic step(input logic [NRT-1:0] vmask, input logic stall);
      logic [NRT-1:0] exp_ready;
      logic [NWP-1:0] exp_en;
      int             free_n;
      int             lim;
      int             n;
      logic           dup;
      bus.rt_xrf_valid_rvv2rvs = vmask;
      bus.xrf_wp_stall         = stall;
      for (int i = 0; i < NRT; i++) begin
         bus.rt_xrf_addr_rvv2rvs[i*AW +: AW]     = lane_addr[i];
         bus.rt_xrf_data_rvv2rvs[i*XLEN +: XLEN] = lane_data[i];
      end
      #1;
      free_n = DEPTH - q.size();
      for (int i = 0; i < NRT; i++) exp_ready[i] = (i < free_n);
      n = 0;
      if (!stall) begin
         lim = (q.size() < NWP) ? q.size() : NWP;
         for (int m = 0; m < lim; m++) begin
            dup = 1'b0;
            for (int p = 0; p < m; p++) if (q[p].a == q[m].a) dup = 1'b1;
            if (dup) break;
            n = m + 1;
         end
      end
      for (int j = 0; j < NWP; j++) exp_en[j] = (j < n);
      chk("ready", bus.rt_xrf_ready_rvs2rvv, exp_ready);
      chk("wb_count", bus.wb_count, q.size());
      chk("wb_idle", bus.wb_idle, q.size() == 0);
      chk("wp_en", bus.xrf_wp_en, exp_en);
      for (int j = 0; j < NWP; j++) begin
         chk("wp_addr", bus.xrf_wp_addr[j*AW +: AW], (j < n) ? q[j].a : '0);
         chk("wp_data", bus.xrf_wp_data[j*XLEN +: XLEN], (j < n) ? q[j].d : '0);
      end
      if (bus.xrf_wp_en[0] && bus.xrf_wp_en[1])
         chk("port_dup", bus.xrf_wp_addr[0 +: AW] == bus.xrf_wp_addr[AW +: AW], 0);
      for (int j = 0; j < NWP; j++)
         if (bus.xrf_wp_en[j]) dut_xrf[bus.xrf_wp_addr[j*AW +: AW]] = bus.xrf_wp_data[j*XLEN +: XLEN];
      for (int j = 0; j < n; j++) void'(q.pop_front());
      for (int i = 0; i < NRT; i++)
         if (vmask[i] && exp_ready[i]) q.push_back('{a: lane_addr[i], d: lane_data[i]});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_lanes(input int base_addr, input int base_data);
      for (int i = 0; i < NRT; i++) begin
         lane_addr[i] = AW'(base_addr + i);
         lane_data[i] = XLEN'(base_data + i);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && q.size() > 0; t++) step('0, 1'b0);
      chk("drain_idle", bus.wb_idle, 1);
   endtask

   initial begin
      int k;
      checks = 0;
      errors = 0;
      for (int r = 0; r < 32; r++) dut_xrf[r] = '0;
      rst_n = 1'b0;
      bus.rt_xrf_valid_rvv2rvs = '0;
      bus.rt_xrf_addr_rvv2rvs  = '0;
      bus.rt_xrf_data_rvv2rvs  = '0;
      bus.xrf_wp_stall         = 1'b0;
      for (int i = 0; i < NRT; i++) begin
         lane_addr[i] = '0;
         lane_data[i] = '0;
      end
      repeat (3) @(negedge clk);
      bus.rt_xrf_valid_rvv2rvs = '1;
      #1;
      chk("rst_ready", bus.rt_xrf_ready_rvs2rvv, 0);
      chk("rst_en", bus.xrf_wp_en, 0);
      chk("rst_count", bus.wb_count, 0);
      chk("rst_idle", bus.wb_idle, 1);
      chk("rst_addr", bus.xrf_wp_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Four lanes x1..x4, two ports per cycle.
      lane_addr[0] = 5'd1; lane_data[0] = 32'd11;
      lane_addr[1] = 5'd2; lane_data[1] = 32'd22;
      lane_addr[2] = 5'd3; lane_data[2] = 32'd33;
      lane_addr[3] = 5'd4; lane_data[3] = 32'd44;
      step(4'b1111, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      chk("t1_x4", dut_xrf[4], 32'd44);

      // Same-address hazard on x5.
      lane_addr[0] = 5'd5; lane_data[0] = 32'hA;
      lane_addr[1] = 5'd5; lane_data[1] = 32'hB;
      step(4'b0011, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      chk("x5_final", dut_xrf[5], 32'hB);

      // Fill under stall, then release.
      set_lanes(8, 100);  step(4'b1111, 1'b1);
      set_lanes(12, 200); step(4'b1111, 1'b1);
      set_lanes(16, 300); step(4'b1111, 1'b1);
      chk("full_count", bus.wb_count, 8);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      drain();

      // Simultaneous accept and drain at count 7.
      set_lanes(20, 400); step(4'b1111, 1'b1);
      set_lanes(24, 500); step(4'b0111, 1'b1);
      set_lanes(27, 600); step(4'b0111, 1'b0);
      chk("simul_count", bus.wb_count, 6);
      drain();

      // Randomized bursts with random stalls and a narrow address range to provoke hazards.
      for (int b = 0; b < 40; b++) begin
         k = $urandom_range(0, NRT);
         for (int i = 0; i < NRT; i++) begin
            lane_addr[i] = AW'($urandom_range(0, 7));
            lane_data[i] = $urandom;
         end
         step(NRT'((1 << k) - 1), ($urandom_range(0, 3) == 0));
      end
      drain();

      // Reset with five entries buffered.
      set_lanes(1, 700); step(4'b1111, 1'b1);
      set_lanes(6, 800); step(4'b0001, 1'b1);
      chk("pre_rst_count", bus.wb_count, 5);
      bus.rt_xrf_valid_rvv2rvs = '1;
      bus.xrf_wp_stall         = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_en", bus.xrf_wp_en, 0);
      chk("midrst_ready", bus.rt_xrf_ready_rvs2rvv, 0);
      chk("midrst_count", bus.wb_count, 0);
      chk("midrst_idle", bus.wb_idle, 1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
